// File: rtl/monox_pkg.sv
// Shared MonoX definitions: lane/group constants, write-back FSM states
// and the lane slicing helper used across the MonoX blocks.
package monox_pkg;

  localparam int LANES  = 4;
  localparam int GROUPS = 2;
  localparam int Q0     = 0;
  localparam int Q1     = 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } wb_state_t;

  // Low bit of lane k in a bus of packed lanes, each w bits wide.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/monox_wb_bank.sv
// Simple dual-port scratch bank: one write port, one registered read port.
module monox_wb_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/monox_wb_seq.sv
// MonoX write-back collector: captures yellow/green lane writes into banked
// scratch memory and drains the frame row by row through a 2-entry skid buffer.
module monox_wb_seq
  import monox_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int INDEX_WIDTH = 13,
  parameter int ADDR_WIDTH  = INDEX_WIDTH - 1,
  parameter int POWER_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES*DATA_WIDTH-1:0]   i_data_y,
  input  logic [LANES*DATA_WIDTH-1:0]   i_data_g,
  input  logic [LANES*ADDR_WIDTH-1:0]   i_addr_y,
  input  logic [LANES*ADDR_WIDTH-1:0]   i_addr_g,
  input  logic [LANES-1:0]              i_we_y,
  input  logic [LANES-1:0]              i_we_g,
  input  logic [POWER_WIDTH-1:0]        i_n,
  input  logic                          i_done,
  output logic [LANES*DATA_WIDTH-1:0]   o_data_y,
  output logic [LANES*DATA_WIDTH-1:0]   o_data_g,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_last,
  output logic [POWER_WIDTH-1:0]        o_n,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int RW = ADDR_WIDTH + 1;
  localparam int LD = LANES * DATA_WIDTH;
  localparam int SW = 2 * LD + 1;
  localparam logic [POWER_WIDTH-1:0] N_MAX = POWER_WIDTH'(ADDR_WIDTH + 2);

  function automatic logic [POWER_WIDTH-1:0] clamp_n(input logic [POWER_WIDTH-1:0] n);
    return (n > N_MAX) ? N_MAX : n;
  endfunction

  // Rows per frame: four coefficients per row, never fewer than one row.
  function automatic logic [RW-1:0] rows_of(input logic [POWER_WIDTH-1:0] n);
    logic [RW-1:0] r;
    r = '0;
    r[0] = 1'b1;
    if (n > POWER_WIDTH'(2)) r = r << (n - POWER_WIDTH'(2));
    return r;
  endfunction

  wb_state_t state, next_state;

  logic [LD-1:0]         wdata [GROUPS];
  logic [LANES*ADDR_WIDTH-1:0] waddr [GROUPS];
  logic [LANES-1:0]      we_req [GROUPS];
  logic [LANES-1:0]      we_ok  [GROUPS];
  logic [DATA_WIDTH-1:0] ram_q  [GROUPS][LANES];
  logic [LD-1:0]         ram_row [GROUPS];

  logic [POWER_WIDTH-1:0] n_eff;
  logic [RW-1:0]          wr_rows, frame_rows, rd_row;
  logic [1:0]             occ, eff;
  logic [SW-1:0]          slot [2];
  logic [SW-1:0]          ram_entry, head;
  logic drop, rd_issue, rd_valid, rd_last;
  logic out_valid, pop, pop_slot, push;

  assign wdata[Q0]  = i_data_y;
  assign wdata[Q1]  = i_data_g;
  assign waddr[Q0]  = i_addr_y;
  assign waddr[Q1]  = i_addr_g;
  assign we_req[Q0] = i_we_y;
  assign we_req[Q1] = i_we_g;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      monox_wb_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_bank (
        .clk  (clk),
        .we   (we_ok[g][k]),
        .waddr(waddr[g][lane_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]),
        .wdata(wdata[g][lane_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
        .re   (rd_issue),
        .raddr(rd_row[ADDR_WIDTH-1:0]),
        .rdata(ram_q[g][k])
      );
    end
  end

  // The first write of a frame is checked against the incoming exponent.
  always_comb begin
    n_eff   = (state == IDLE) ? clamp_n(i_n) : o_n;
    wr_rows = rows_of(n_eff);
    drop    = 1'b0;
    for (int g = 0; g < GROUPS; g++) begin
      we_ok[g] = '0;
      for (int k = 0; k < LANES; k++) begin
        if (we_req[g][k]) begin
          if (state != DRAIN && {1'b0, waddr[g][k*ADDR_WIDTH +: ADDR_WIDTH]} < wr_rows)
            we_ok[g][k] = 1'b1;
          else
            drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int g = 0; g < GROUPS; g++)
      for (int k = 0; k < LANES; k++)
        ram_row[g][k*DATA_WIDTH +: DATA_WIDTH] = ram_q[g][k];
  end

  // RAM data bypasses the skid buffer when it is empty, so no bubble is added.
  assign frame_rows = rows_of(o_n);
  assign ram_entry  = {rd_last, ram_row[Q1], ram_row[Q0]};
  assign head       = (occ != 2'd0) ? slot[0] : ram_entry;
  assign out_valid  = (occ != 2'd0) || rd_valid;
  assign pop        = out_valid && i_ready;
  assign pop_slot   = pop && (occ != 2'd0);
  assign push       = rd_valid && !(occ == 2'd0 && pop);
  assign eff        = occ - {1'b0, pop_slot};
  assign rd_issue   = (state == DRAIN) && (rd_row < frame_rows) &&
                      ((occ + {1'b0, rd_valid}) < 2'd2);

  assign o_valid  = out_valid;
  assign o_last   = out_valid && head[SW-1];
  assign o_data_y = out_valid ? head[LD-1:0] : '0;
  assign o_data_g = out_valid ? head[2*LD-1:LD] : '0;
  assign o_busy   = (state != IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_done)                      next_state = DRAIN;
        else if (|{i_we_y, i_we_g})      next_state = FILL;
      end
      FILL:  if (i_done) next_state = DRAIN;
      DRAIN: if (pop && head[SW-1]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_n      <= '0;
      o_err    <= 1'b0;
      o_done   <= 1'b0;
      rd_row   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      occ      <= 2'd0;
    end else begin
      o_done   <= (state == DRAIN) && (next_state == IDLE);
      o_err    <= o_err | drop;
      rd_valid <= rd_issue;
      occ      <= occ + {1'b0, push} - {1'b0, pop_slot};
      if (state == IDLE && next_state != IDLE) o_n <= clamp_n(i_n);
      if (rd_issue) begin
        rd_last <= (rd_row == frame_rows - 1'b1);
        rd_row  <= rd_row + 1'b1;
      end
      if (state == DRAIN && next_state == IDLE) rd_row <= '0;
    end
  end

  // Skid storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (pop_slot) slot[0] <= slot[1];
    if (push) begin
      if (eff == 2'd0) slot[0] <= ram_entry;
      else             slot[1] <= ram_entry;
    end
  end

endmodule

// File: tb/tb_monox_wb_seq.sv
// Directed self-checking bench for the MonoX write-back collector.
module tb_monox_wb_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] i_data_y, i_data_g;
  logic [47:0]  i_addr_y, i_addr_g;
  logic [3:0]   i_we_y, i_we_g;
  logic [3:0]   i_n;
  logic         i_done, i_ready;
  logic [255:0] o_data_y, o_data_g;
  logic         o_valid, o_last, o_busy, o_done, o_err;
  logic [3:0]   o_n;

  int checks = 0;
  int errors = 0;
  logic [255:0] ey [4];
  logic [255:0] eg [4];

  monox_wb_seq dut (
    .clk(clk), .rst(rst),
    .i_data_y(i_data_y), .i_data_g(i_data_g),
    .i_addr_y(i_addr_y), .i_addr_g(i_addr_g),
    .i_we_y(i_we_y), .i_we_g(i_we_g),
    .i_n(i_n), .i_done(i_done),
    .o_data_y(o_data_y), .o_data_g(o_data_g),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_n(o_n), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of writes (same row on every lane), then idle the inputs.
  task automatic applyStimulus(input logic [3:0] wy, input logic [3:0] wg, input logic [11:0] row,
                               input logic [255:0] dy, input logic [255:0] dg, input logic done);
    i_we_y = wy; i_we_g = wg;
    i_addr_y = {4{row}}; i_addr_g = {4{row}};
    i_data_y = dy; i_data_g = dg;
    i_done = done;
    @(negedge clk);
    i_we_y = '0; i_we_g = '0; i_done = 1'b0;
  endtask

  task automatic writeFrame();
    for (int r = 0; r < 4; r++) applyStimulus(4'hF, 4'hF, 12'(r), ey[r], eg[r], 1'b0);
  endtask

  task automatic drainRows(input int rows);
    for (int r = 0; r < rows; r++) begin
      checkOutput("drain_valid", o_valid, 1);
      checkOutput("drain_y", o_data_y, ey[r]);
      checkOutput("drain_g", o_data_g, eg[r]);
      checkOutput("drain_last", o_last, (r == rows - 1) ? 1 : 0);
      @(negedge clk);
    end
    checkOutput("done_pulse", o_done, 1);
    checkOutput("busy_low", o_busy, 0);
    checkOutput("valid_low", o_valid, 0);
    @(negedge clk);
    checkOutput("done_once", o_done, 0);
  endtask

  initial begin
    int got;
    logic stalled;
    logic [255:0] tmp;

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        ey[r][k*64 +: 64] = 64'(256 * r + k);
        eg[r][k*64 +: 64] = 64'(256 * r + k + 'h1000);
      end

    rst = 1'b1; i_we_y = '0; i_we_g = '0; i_addr_y = '0; i_addr_g = '0;
    i_data_y = '0; i_data_g = '0; i_n = 4'd4; i_done = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_n", o_n, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_last", o_last, 0);
    checkOutput("rst_data_y", o_data_y, 0);
    checkOutput("rst_data_g", o_data_g, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic frame n=4");
    writeFrame();
    checkOutput("fill_busy", o_busy, 1);
    applyStimulus('0, '0, 12'd0, '0, '0, 1'b1);
    checkOutput("t1_valid", o_valid, 0);
    checkOutput("t1_n", o_n, 4);
    @(negedge clk);
    drainRows(4);

    $display("[TB] stale frame with back-pressure");
    applyStimulus('0, '0, 12'd0, '0, '0, 1'b1);
    got = 0;
    stalled = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      i_ready = (cyc % 3 == 0);
      if (stalled) checkOutput("bp_hold_valid", o_valid, 1);
      stalled = 1'b0;
      if (o_valid) begin
        checkOutput("bp_y", o_data_y, ey[got]);
        checkOutput("bp_g", o_data_g, eg[got]);
        checkOutput("bp_last", o_last, (got == 3) ? 1 : 0);
        if (i_ready) got++;
        else stalled = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("bp_rows", 256'(got), 4);
    checkOutput("bp_done", o_done, 1);
    i_ready = 1'b1;
    @(negedge clk);

    $display("[TB] out-of-range write");
    writeFrame();
    tmp = '1;
    applyStimulus(4'b0001, '0, 12'd5, tmp, '0, 1'b0);
    checkOutput("oor_err", o_err, 1);
    applyStimulus('0, '0, 12'd0, '0, '0, 1'b1);
    checkOutput("oor_t1_valid", o_valid, 0);
    @(negedge clk);
    drainRows(4);
    checkOutput("oor_err_sticky", o_err, 1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("err_cleared", o_err, 0);

    $display("[TB] write with done and write during drain");
    applyStimulus(4'hF, 4'hF, 12'd0, ey[0], eg[0], 1'b0);
    tmp = '0;
    tmp[2*64 +: 64] = 64'hABCD;
    eg[1][2*64 +: 64] = 64'hABCD;
    applyStimulus('0, 4'b0100, 12'd1, '0, tmp, 1'b1);
    checkOutput("dw_t1_valid", o_valid, 0);
    checkOutput("dw_t1_busy", o_busy, 1);
    checkOutput("dw_t1_err", o_err, 0);
    tmp = '0;
    tmp[1*64 +: 64] = 64'hBEEF;
    applyStimulus(4'b0010, '0, 12'd2, tmp, '0, 1'b0);
    checkOutput("dw_err", o_err, 1);
    drainRows(4);

    $display("[TB] single-row frame n=0");
    i_n = 4'd0;
    tmp = ey[0];
    tmp[63:0] = 64'h55;
    ey[0][63:0] = 64'h55;
    applyStimulus(4'b0001, '0, 12'd0, tmp, '0, 1'b0);
    applyStimulus('0, '0, 12'd0, '0, '0, 1'b1);
    checkOutput("n0_o_n", o_n, 0);
    checkOutput("n0_t1_valid", o_valid, 0);
    @(negedge clk);
    drainRows(1);

    $display("[TB] exponent clamp");
    i_n = 4'd15;
    applyStimulus('0, '0, 12'd0, '0, '0, 1'b1);
    checkOutput("clamp_n", o_n, 14);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_n = 4'd4;
    checkOutput("clamp_rst_n", o_n, 0);

    $display("[TB] reset during drain");
    applyStimulus('0, '0, 12'd0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("mid_row0", o_data_y, ey[0]);
    @(negedge clk);
    checkOutput("mid_row1", o_data_y, ey[1]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_valid", o_valid, 0);
    checkOutput("mid_rst_busy", o_busy, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        ey[r][k*64 +: 64] = ey[r][k*64 +: 64] + 64'h20000;
        eg[r][k*64 +: 64] = eg[r][k*64 +: 64] + 64'h20000;
      end
    end
    writeFrame();
    applyStimulus('0, '0, 12'd0, '0, '0, 1'b1);
    checkOutput("fresh_t1_valid", o_valid, 0);
    @(negedge clk);
    drainRows(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/monox_wb_seq.md
# monox_wb_seq

Write-back collector sitting directly downstream of the MonoX sequential stage. It captures the 4-lane yellow (Q0) and green (Q1) result writes into two internal 4-bank scratch memories. Once the upstream done pulse arrives, it streams the frame out row by row over a valid/ready interface to the next stage (addx). It forwards the frame's power-of-2 size alongside the data.

## Interface
- DATA_WIDTH, 64: bits per coefficient lane
- INDEX_WIDTH, 13: inner index width
- ADDR_WIDTH, INDEX_WIDTH-1: per-bank row address width; bank depth 2^ADDR_WIDTH
- POWER_WIDTH, 4: width of size exponent n

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- i_data_y  in  4*DATA_WIDTH  yellow lanes, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_data_g  in  4*DATA_WIDTH  green lanes, same packing
- i_addr_y  in  4*ADDR_WIDTH  yellow per-lane row address
- i_addr_g  in  4*ADDR_WIDTH  green per-lane row address
- i_we_y  in  4  yellow per-lane write enable
- i_we_g  in  4  green per-lane write enable
- i_n  in  POWER_WIDTH  frame size exponent, N = 2^i_n coefficients
- i_done  in  1  upstream frame-complete pulse
- o_data_y  out  4*DATA_WIDTH  yellow row out; bank k on lane k
- o_data_g  out  4*DATA_WIDTH  green row out
- o_valid  out  1  output row valid
- i_ready  in  1  downstream accepts row
- o_last  out  1  high with the final row of the frame
- o_n  out  POWER_WIDTH  latched frame exponent, stable during drain
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse after the last handshake
- o_err  out  1  sticky: a write was dropped; cleared only by rst

## Operation
- FSM states: IDLE, FILL, DRAIN.
- IDLE → FILL: on any `i_we_y|i_we_g` bit high. That write is performed. i_n is latched into o_n in the same cycle.
- FILL:
  - Each lane k with its we high writes its data to bank k of its group at its lane address.
  - Yellow and green are independent.
  - All 8 lane writes in one cycle are legal.
- Frame rows R = max(1, 2^o_n / 4). o_n is clamped to ADDR_WIDTH+2.
- Write with address ≥ R: dropped, o_err set.
- FILL → DRAIN: i_done sampled high. Writes in that same cycle are still performed.
- i_done in IDLE: enter DRAIN with o_n = i_n. This is the zero-write frame; it outputs stale contents.
- DRAIN:
  - Reads row r = 0..R-1, all 4 banks of both groups at the same address.
  - Writes arriving in DRAIN are dropped and set o_err.
  - i_done in DRAIN is ignored.
- Output path: a 2-entry skid buffer. A read is issued only when (occupancy + reads in flight) < 2.
- Handshake: a row transfers when o_valid && i_ready.
  - Data, o_last and o_valid hold steady while o_valid && !i_ready.
  - o_valid never drops without a handshake.
- Last row handshake → IDLE. o_done pulses in the next cycle.
- Memory contents are not cleared by reset or between frames.

## Timing
- Reset: all outputs 0 (o_data_y, o_data_g, o_valid, o_last, o_n, o_busy, o_done, o_err). FSM goes to IDLE, skid is emptied, read counter is 0.
- Reset mid-FILL or mid-DRAIN: next cycle is IDLE. Any in-flight row is discarded.
- RAM read latency: 1 cycle, registered.
- Latency: i_done high in cycle t gives o_valid first high in cycle t+2.
- Throughput: 1 row/cycle with i_ready held high. A frame of R rows drains in cycles t+2 .. t+R+1.
- Back-pressure: after i_ready rises again, the next row is presented the same cycle. There are no bubbles from the skid buffer.
- o_done: cycle after the last handshake. o_busy falls the same cycle.
- A new frame's first write is accepted the cycle o_done is high.

## Structure
- Shared package `monox_pkg`: lane count (4), Q0/Q1 constants, FSM state enum, lane slice helper. Reuse it if it already exists.
- Sub-module `monox_wb_bank`: a simple dual-port RAM, one write port and one registered read port, ADDR_WIDTH × DATA_WIDTH. Instantiate it 8 times (2 groups × 4 lanes).
- FSM, row counter, skid buffer and error logic stay in the top module.

## Test plan
- i_n=4 (R=4): write rows 0..3 with yellow lane k = 0x100·row+k and green = yellow+0x1000, then pulse i_done, ready high → 4 consecutive rows in order from i_done+2; o_last on row 3; o_done the next cycle; o_n=4.
- Same frame, i_ready toggling 1,0,0,1,… → no row lost or duplicated; data stable while stalled.
- Write to address 5 with i_n=4 → dropped, o_err=1 and sticky; the frame drains normally.
- Write in the same cycle as i_done → the data appears in the drained output. A write during DRAIN → not stored, o_err=1.
- i_n=0 → R=1; a single row with o_last=1.
- rst asserted mid-DRAIN after 2 rows → next cycle: o_valid=0, o_busy=0. A fresh frame then completes correctly.
